// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader in front of the instruction RAM.
// Holds the CPU core in reset, takes a length-prefixed little-endian image
// (CNT_L, CNT_H, then 4*N payload bytes, LSB first per word), writes each
// assembled word to consecutive word addresses from 0, then releases the core.
//
// Build option: define LOADER_CHECKSUM_EN to require one trailing byte equal
// to the XOR of every accepted byte (header included); mismatch aborts.
//
// Parameters:
//   ADDR_W      instruction-memory word-address width (capacity 2**ADDR_W)
// Ports:
//   CLK         system clock, rising edge
//   RSTn        asynchronous active-low reset
//   rx_valid    byte present on rx_data
//   rx_data     stream byte
//   rx_ready    loader can accept a byte (decoded from state)
//   load_req    single-cycle pulse: restart the load from any state
//   imem_we     write strobe, one cycle per completed word
//   imem_addr   word index being written
//   imem_wdata  assembled instruction word
//   core_rstn   active-low core reset, released one cycle after done
//   done        image loaded, core running
//   error       load aborted, core held in reset
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rstn,
  output logic              done,
  output logic              error
);

  localparam int unsigned WI_W = ADDR_W + 1;
  localparam logic [WI_W-1:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [WI_W-1:0]   n_q, n_d;
  logic [WI_W-1:0]   widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rstn_q, core_rstn_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] n16;
  logic        last_word;

  assign rx_ready   = (state_q != S_RUN) && (state_q != S_ERR);
  assign done       = (state_q == S_RUN);
  assign error      = (state_q == S_ERR);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rstn  = core_rstn_q;

  assign accept    = rx_valid && rx_ready;
  assign n16       = {rx_data, cnt_lo_q};
  assign last_word = (widx_q == (n_q - WI_W'(1)));

  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    n_d         = n_q;
    widx_d      = widx_q;
    bidx_d      = bidx_q;
    asm_d       = asm_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    core_rstn_d = core_rstn_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    if (load_req) begin
      // Restart wins over a coincident byte: the byte is dropped.
      state_d     = S_HDR0;
      widx_d      = '0;
      bidx_d      = '0;
      asm_d       = '0;
      core_rstn_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d      = '0;
`endif
    end else begin
      // Registered from state so the core leaves reset one edge after RUN
      // is entered, after the final write has landed.
      core_rstn_d = (state_q == S_RUN);
      if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
        case (state_q)
          S_HDR0: begin
            cnt_lo_d = rx_data;
            state_d  = S_HDR1;
          end
          S_HDR1: begin
            if (32'(n16) > 32'(CAP)) begin
              state_d = S_ERR;
            end else if (n16 == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_RUN;
`endif
            end else begin
              n_d     = WI_W'(n16);
              widx_d  = '0;
              bidx_d  = '0;
              state_d = S_DATA;
            end
          end
          S_DATA: begin
            case (bidx_q)
              2'd0: asm_d[7:0]   = rx_data;
              2'd1: asm_d[15:8]  = rx_data;
              2'd2: asm_d[23:16] = rx_data;
              default: begin
                we_d    = 1'b1;
                addr_d  = widx_q[ADDR_W-1:0];
                wdata_d = {rx_data, asm_q};
                widx_d  = widx_q + WI_W'(1);
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_RUN;
`endif
                end
              end
            endcase
            bidx_d = bidx_q + 2'd1;
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_HDR0;
      cnt_lo_q    <= '0;
      n_q         <= '0;
      widx_q      <= '0;
      bidx_q      <= '0;
      asm_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      core_rstn_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      n_q         <= n_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      asm_q       <= asm_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      core_rstn_q <= core_rstn_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of image vectors, randomized
// images with optional aborts, and hand-written timing/corner sequences.
module tb_imem_loader;

  localparam int unsigned AW  = 10;
  localparam int unsigned CAP = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          load_req = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rstn;
  logic          done;
  logic          error;

  always #5 CLK = ~CLK;

  imem_loader #(.ADDR_W(AW)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rstn  (core_rstn),
    .done       (done),
    .error      (error)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t          exp_q[$];
  wr_t          mon_e;
  logic [31:0]  wq[$];
  logic [7:0]   stream[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Write monitor: every strobe must match the next expected word.
  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(mon_e.addr));
        chk("write_data", imem_wdata, mon_e.data);
      end
    end
  end

  // Reference stream: header, words from wq LSB first, optional checksum.
  // An oversize count yields the header only (nothing after it is taken).
  task automatic build(input int unsigned n, input bit bad_cs);
    logic [7:0] x;
    stream.delete();
    stream.push_back(8'(n & 32'hFF));
    stream.push_back(8'((n >> 8) & 32'hFF));
    if (n <= CAP) begin
      for (int unsigned i = 0; i < n; i++)
        for (int unsigned k = 0; k < 4; k++)
          stream.push_back(8'((wq[i] >> (8 * k)) & 32'hFF));
`ifdef LOADER_CHECKSUM_EN
      x = '0;
      foreach (stream[i]) x = x ^ stream[i];
      if (bad_cs) x = x ^ 8'h03;
      stream.push_back(x);
`else
      x = {7'd0, bad_cs};
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (rx_ready === 1'b1) begin
        @(posedge CLK);
        #1;
        ok = 1'b1;
      end
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, rx_ready 0 expected 1", b);
    end
  endtask

  // Sends the first lim bytes; expectation of a write is queued when a byte
  // that completes payload word i (i < n) goes out.
  task automatic send_stream(input int unsigned n, input int unsigned lim, input bit gaps);
    for (int unsigned p = 0; p < stream.size() && p < lim; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
      if (p >= 2 && ((p - 2) % 4) == 3 && ((p - 2) / 4) < n)
        exp_q.push_back('{addr: AW'((p - 2) / 4), data: wq[(p - 2) / 4]});
      send_byte(stream[p]);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge CLK);
    #1;
    load_req = 1'b0;
  endtask

  task automatic fill_words(input int unsigned n);
    wq.delete();
    if (n <= CAP)
      for (int unsigned i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  task automatic check_outcome(input string tag, input bit exp_done, input bit exp_err);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_core_rstn_held"}, 32'(core_rstn), 32'd0);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(!(exp_done || exp_err)));
    @(posedge CLK);
    #1;
    chk({tag, "_core_rstn_late"}, 32'(core_rstn), 32'(exp_done));
    chk({tag, "_writes_left"}, exp_q.size(), 32'd0);
  endtask

  typedef struct {
    int unsigned n;
    bit          bad_cs;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vt[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{n: 0,        bad_cs: 0, gaps: 0, exp_done: 1,   exp_err: 0};
    vt[1] = '{n: 1,        bad_cs: 0, gaps: 0, exp_done: 1,   exp_err: 0};
    vt[2] = '{n: 3,        bad_cs: 0, gaps: 1, exp_done: 1,   exp_err: 0};
    vt[3] = '{n: 7,        bad_cs: 0, gaps: 1, exp_done: 1,   exp_err: 0};
    vt[4] = '{n: 5,        bad_cs: 1, gaps: 0, exp_done: !CS, exp_err: CS};
    vt[5] = '{n: CAP + 1,  bad_cs: 0, gaps: 0, exp_done: 0,   exp_err: 1};
    vt[6] = '{n: 16'hFFFF, bad_cs: 0, gaps: 0, exp_done: 0,   exp_err: 1};
    vt[7] = '{n: CAP,      bad_cs: 0, gaps: 0, exp_done: 1,   exp_err: 0};

    // Reset values
    #12;
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_rstn", 32'(core_rstn), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;

    // Known image from the plan, with exact write/done/core_rstn timing
    wq = '{32'h00A0_0513, 32'h00B0_0593};
    build(2, 1'b0);
    send_stream(2, stream.size(), 1'b0);
    chk("n2_we_at_last", 32'(imem_we), 32'(!CS));
    chk("n2_done", 32'(done), 32'd1);
    chk("n2_core_rstn_held", 32'(core_rstn), 32'd0);
    @(posedge CLK);
    #1;
    chk("n2_core_rstn_rel", 32'(core_rstn), 32'd1);
    chk("n2_we_single", 32'(imem_we), 32'd0);
    chk("n2_writes_left", exp_q.size(), 32'd0);

    // Asynchronous reset while running: outputs drop without a clock edge
    #3;
    RSTn = 1'b0;
    #1;
    chk("arst_imem_addr", 32'(imem_addr), 32'd0);
    chk("arst_imem_wdata", imem_wdata, 32'd0);
    chk("arst_core_rstn", 32'(core_rstn), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;

    // Table-driven images
    foreach (vt[i]) begin
      pulse_load();
      fill_words(vt[i].n);
      build(vt[i].n, vt[i].bad_cs);
      send_stream(vt[i].n, stream.size(), vt[i].gaps);
      check_outcome($sformatf("vec%0d", i), vt[i].exp_done, vt[i].exp_err);
    end

    // load_req together with a byte mid-word: byte dropped, no write
    pulse_load();
    wq = '{32'h1234_5678};
    build(1, 1'b0);
    send_stream(1, 4, 1'b0);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    load_req = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    load_req = 1'b0;
    chk("drop_rx_ready", 32'(rx_ready), 32'd1);
    chk("drop_done", 32'(done), 32'd0);
    chk("drop_no_we", 32'(imem_we), 32'd0);
    fill_words(1);
    build(1, 1'b0);
    send_stream(1, stream.size(), 1'b0);
    check_outcome("after_drop", 1'b1, 1'b0);

    // load_req from RUN, then a reload overwriting word 0
    pulse_load();
    chk("run_reload_done", 32'(done), 32'd0);
    chk("run_reload_core_rstn", 32'(core_rstn), 32'd0);
    wq = '{32'hDEAD_BEEF};
    build(1, 1'b0);
    send_stream(1, stream.size(), 1'b0);
    check_outcome("deadbeef", 1'b1, 1'b0);

    // Randomized images, some aborted part-way
    for (int it = 0; it < 24; it++) begin
      int unsigned n;
      bit          bad, gaps, abort;
      n     = $urandom_range(1, 12);
      bad   = 1'($urandom_range(0, 1));
      gaps  = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 3) == 0);
      pulse_load();
      fill_words(n);
      build(n, bad);
      if (abort) begin
        send_stream(n, $urandom_range(1, stream.size() - 1), gaps);
        pulse_load();
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        chk("abort_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge CLK);
        #1;
        chk("abort_writes_left", exp_q.size(), 32'd0);
      end else begin
        send_stream(n, stream.size(), gaps);
        check_outcome($sformatf("rand%0d", it), !(CS && bad), CS && bad);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
